// File: rtl/bnn_popcount_binarizer_if.sv
// Popcount-stream interface between the XNOR/popcount stage and the binarizer,
// carrying the packed activation words back out. Valid is iEN; there is no ready.
interface bnn_popcount_binarizer_if #(
  parameter int WL = 112,
  parameter int CW = 11,
  parameter int AW = 14
);
  logic          iCLR;
  logic          iEN;
  logic [CW-1:0] idata;
  logic [AW-1:0] iTHRESH;
  logic          iLAST;
  logic [WL-1:0] odata;
  logic          oEN;
  logic [7:0]    oWCNT;

  modport master (
    output iCLR, iEN, idata, iTHRESH, iLAST,
    input  odata, oEN, oWCNT
  );

  modport slave (
    input  iCLR, iEN, idata, iTHRESH, iLAST,
    output odata, oEN, oWCNT
  );
endinterface

// File: rtl/bnn_popcount_binarizer.sv
// Sums NSEG popcount beats per neuron, thresholds the sum to one sign bit and
// packs the bits LSB-first into WL-bit activation words (flushed early on iLAST).
module bnn_popcount_binarizer #(
  parameter int WL   = 112,
  parameter int CW   = 11,
  parameter int NSEG = 4,
  parameter int AW   = 14
) (
  input logic                   iCLK,
  input logic                   iRST,
  bnn_popcount_binarizer_if.slave pif
);
  localparam int SEGW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int BPW  = (WL > 1) ? $clog2(WL) : 1;
  localparam logic [SEGW-1:0] SEG_LAST = SEGW'(NSEG - 1);
  localparam logic [BPW-1:0]  BP_LAST  = BPW'(WL - 1);
  localparam logic [SEGW-1:0] SEG_ONE  = SEGW'(1);
  localparam logic [BPW-1:0]  BP_ONE   = BPW'(1);

  logic [SEGW-1:0] seg;
  logic [AW-1:0]   acc;
  logic [BPW-1:0]  bp;
  logic [WL-1:0]   sw;

  logic [AW-1:0]   sum;
  logic            final_beat;
  logic            neuron_bit;
  logic [WL-1:0]   word_next;
  logic            emit;

  // sw only ever holds bits below bp, so OR-ing the new bit in leaves the
  // bits above bp at zero without an explicit mask.
  always_comb begin
    sum        = acc + AW'(pif.idata);
    final_beat = (seg == SEG_LAST);
    neuron_bit = (sum >= pif.iTHRESH);
    word_next  = sw | (WL'(neuron_bit) << bp);
    emit       = final_beat && ((bp == BP_LAST) || pif.iLAST);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      seg       <= '0;
      acc       <= '0;
      bp        <= '0;
      sw        <= '0;
      pif.odata <= '0;
      pif.oEN   <= 1'b0;
      pif.oWCNT <= '0;
    end else if (pif.iCLR) begin
      // odata deliberately keeps the last emitted word
      seg       <= '0;
      acc       <= '0;
      bp        <= '0;
      sw        <= '0;
      pif.oEN   <= 1'b0;
      pif.oWCNT <= '0;
    end else begin
      pif.oEN <= 1'b0;
      if (pif.iEN) begin
        if (!final_beat) begin
          acc <= sum;
          seg <= seg + SEG_ONE;
        end else begin
          acc <= '0;
          seg <= '0;
          if (emit) begin
            pif.odata <= word_next;
            pif.oEN   <= 1'b1;
            pif.oWCNT <= pif.oWCNT + 8'd1;
            sw        <= '0;
            bp        <= '0;
          end else begin
            sw <= word_next;
            bp <= bp + BP_ONE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_bnn_popcount_binarizer.sv
// Directed bench: NSEG=4 instance for word/flush/boundary/clear cases,
// NSEG=1 instance for 256-word wrap at full throughput.
module tb_bnn_popcount_binarizer;
  localparam int WL = 112;
  localparam int CW = 11;
  localparam int AW = 14;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bnn_popcount_binarizer_if #(.WL(WL), .CW(CW), .AW(AW)) if4 ();
  bnn_popcount_binarizer_if #(.WL(WL), .CW(CW), .AW(AW)) if1 ();

  bnn_popcount_binarizer #(.WL(WL), .CW(CW), .NSEG(4), .AW(AW)) u_dut4 (
    .iCLK(clk), .iRST(rst), .pif(if4.slave)
  );
  bnn_popcount_binarizer #(.WL(WL), .CW(CW), .NSEG(1), .AW(AW)) u_dut1 (
    .iCLK(clk), .iRST(rst), .pif(if1.slave)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboards ----------------
  logic [WL-1:0] exp_q[$];
  logic [WL-1:0] exp1_q[$];
  int pulses4 = 0;
  int pulses1 = 0;
  int last_pulse1 = 0;

  always @(negedge clk) begin
    if (!rst && if4.oEN === 1'b1) begin
      pulses4++;
      if (exp_q.size() == 0) check("unexpected_word4", 128'd1, 128'd0);
      else check("word4", 128'(if4.odata), 128'(exp_q.pop_front()));
    end
    if (!rst && if1.oEN === 1'b1) begin
      if (pulses1 > 0) check("spacing1", 128'(cyc - last_pulse1), 128'(WL));
      last_pulse1 = cyc;
      pulses1++;
      if (exp1_q.size() == 0) check("unexpected_word1", 128'd1, 128'd0);
      else check("word1", 128'(if1.odata), 128'(exp1_q.pop_front()));
    end
  end

  // ---------------- drivers ----------------
  task automatic beat4(input logic [CW-1:0] d, input logic [AW-1:0] t, input logic last);
    @(negedge clk);
    if4.iCLR = 1'b0; if4.iEN = 1'b1; if4.idata = d; if4.iTHRESH = t; if4.iLAST = last;
  endtask

  task automatic neuron4(input logic [CW-1:0] d, input logic [AW-1:0] t, input logic last);
    for (int b = 0; b < 4; b++) beat4(d, t, (b == 3) ? last : 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if4.iCLR = 1'b0; if4.iEN = 1'b0; if4.iLAST = 1'b0;
      if1.iCLR = 1'b0; if1.iEN = 1'b0; if1.iLAST = 1'b0;
    end
  endtask

  task automatic beat1(input logic [CW-1:0] d, input logic [AW-1:0] t);
    @(negedge clk);
    if1.iCLR = 1'b0; if1.iEN = 1'b1; if1.idata = d; if1.iTHRESH = t; if1.iLAST = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [WL-1:0] w;
  logic [CW-1:0] d1[WL];
  logic [AW-1:0] t1[WL];

  initial begin
    if4.iCLR = 1'b0; if4.iEN = 1'b0; if4.idata = '0; if4.iTHRESH = '0; if4.iLAST = 1'b0;
    if1.iCLR = 1'b0; if1.iEN = 1'b0; if1.idata = '0; if1.iTHRESH = '0; if1.iLAST = 1'b0;

    // reset held over random beats
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if4.iEN = 1'($urandom_range(0, 1)); if4.idata = CW'($urandom_range(0, 2047));
      if1.iEN = 1'($urandom_range(0, 1)); if1.idata = CW'($urandom_range(0, 2047));
    end
    @(negedge clk);
    rst = 1'b0; if4.iEN = 1'b0; if1.iEN = 1'b0;
    check("rst_odata", 128'(if4.odata), 128'd0);
    check("rst_oen",   128'(if4.oEN),   128'd0);
    check("rst_wcnt",  128'(if4.oWCNT), 128'd0);
    check("rst_wcnt1", 128'(if1.oWCNT), 128'd0);

    // full word: sum 120, even thresh 120 -> 1, odd 121 -> 0
    w = '0;
    for (int i = 0; i < WL; i += 2) w[i] = 1'b1;
    exp_q.push_back(w);
    for (int i = 0; i < WL; i++) neuron4(11'd30, (i % 2 == 1) ? 14'd121 : 14'd120, 1'b0);
    idle(2);
    check("full_wcnt",   128'(if4.oWCNT), 128'd1);
    check("full_pulses", 128'(pulses4),   128'd1);

    // partial flush after 5 neurons
    exp_q.push_back(WL'(112'h1F));
    for (int i = 0; i < 5; i++) neuron4(11'd30, 14'd100, (i == 4));
    idle(2);
    check("flush_wcnt",   128'(if4.oWCNT), 128'd2);
    check("flush_pulses", 128'(pulses4),   128'd2);

    // boundaries, fresh word from bit 0: 448>=448, 448<449, 0>=0, 4<5, 4>=2
    exp_q.push_back(WL'(112'h15));
    neuron4(11'd112, 14'd448, 1'b0);
    neuron4(11'd112, 14'd449, 1'b0);
    neuron4(11'd0,   14'd0,   1'b0);
    beat4(11'd1, 14'd5, 1'b0);
    beat4(11'd1, 14'd5, 1'b1);   // iLAST on a non-final beat
    beat4(11'd1, 14'd5, 1'b0);
    beat4(11'd1, 14'd5, 1'b0);
    idle(2);
    check("misplaced_last_pulses", 128'(pulses4), 128'd2);
    neuron4(11'd1, 14'd2, 1'b1);
    idle(2);
    check("bound_wcnt",   128'(if4.oWCNT), 128'd3);
    check("bound_pulses", 128'(pulses4),   128'd3);
    check("idle_oen",     128'(if4.oEN),   128'd0);

    // clear mid-word and mid-neuron, with a coincident beat
    neuron4(11'd10, 14'd0, 1'b0);
    neuron4(11'd10, 14'd0, 1'b0);
    beat4(11'd500, 14'd0, 1'b0);
    beat4(11'd500, 14'd0, 1'b0);
    @(negedge clk);
    if4.iCLR = 1'b1; if4.iEN = 1'b1; if4.idata = 11'd500; if4.iLAST = 1'b1;
    idle(2);
    check("clr_pulses",     128'(pulses4),   128'd3);
    check("clr_wcnt",       128'(if4.oWCNT), 128'd0);
    check("clr_odata_hold", 128'(if4.odata), 128'h15);
    exp_q.push_back(WL'(112'h2));
    neuron4(11'd10, 14'd41, 1'b0);
    neuron4(11'd10, 14'd40, 1'b1);
    idle(2);
    check("post_clr_wcnt",   128'(if4.oWCNT), 128'd1);
    check("post_clr_pulses", 128'(pulses4),   128'd4);

    // NSEG=1: 256 back-to-back words, wcnt wraps to 0
    for (int wi = 0; wi < 256; wi++) begin
      w = '0;
      for (int i = 0; i < WL; i++) begin
        d1[i] = CW'($urandom_range(0, 2047));
        t1[i] = (i == 0) ? 14'd0 : AW'($urandom_range(0, 2100));
        w[i]  = (AW'(d1[i]) >= t1[i]);
      end
      exp1_q.push_back(w);
      for (int i = 0; i < WL; i++) beat1(d1[i], t1[i]);
    end
    idle(3);
    check("wrap_pulses", 128'(pulses1),     128'd256);
    check("wrap_wcnt",   128'(if1.oWCNT),   128'd0);
    check("q4_empty",    128'(exp_q.size()),  128'd0);
    check("q1_empty",    128'(exp1_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bnn_popcount_binarizer.md
# bnn_popcount_binarizer

Consumes the popcount stream from the XNOR/popcount stage (one 11-bit count per 112-bit segment, strobed by an enable). It accumulates NSEG segment counts per output neuron and binarizes each neuron by comparing the sum against a threshold. The resulting sign bits are packed LSB-first into WL-bit activation words, which are the next layer's binarized input. This block is the reader side of the popcount interface; it provides no back-pressure.

## Interface
- WL, 112: activation word width (bits packed per output word)
- CW, 11: popcount input width
- NSEG, 4: popcount segments summed per neuron (1..8)
- AW, 14: accumulator/threshold width; must satisfy AW ≥ CW + ceil(log2(NSEG))
- iCLK  in  1  clock, rising edge
- iRST  in  1  asynchronous, active-high reset
- iCLR  in  1  synchronous layer restart; clears all state except outputs
- iEN  in  1  popcount beat valid
- idata  in  CW  popcount value, unsigned
- iTHRESH  in  AW  neuron threshold, unsigned; sampled only on a neuron's final beat
- iLAST  in  1  last neuron of layer; sampled only on a neuron's final beat
- odata  out  WL  packed activation word; bit n = neuron n of the word
- oEN  out  1  one-cycle strobe, odata valid
- oWCNT  out  8  words emitted since reset/iCLR, wraps 255→0

## Operation
- Internal state: seg counter (0..NSEG-1), accumulator acc[AW], bit pointer bp (0..WL-1), shift word sw[WL].
- Beat (iEN=1, iCLR=0), seg<NSEG-1: acc ← acc + idata; seg ← seg+1.
- Final beat (seg=NSEG-1): sum = acc + idata (AW-bit, unsigned, no overflow by width rule); bit = (sum ≥ iTHRESH); sw[bp] ← bit; acc ← 0; seg ← 0.
  - If bp=WL-1 or iLAST=1: odata ← sw with new bit inserted, bits above bp forced 0; oEN ← 1; oWCNT ← oWCNT+1; sw ← 0; bp ← 0.
  - Otherwise bp ← bp+1.
- NSEG=1: every beat is a final beat.
- iLAST on a non-final beat is ignored. iLAST with bp=WL-1 emits one word, not two.
- iCLR=1: seg, acc, bp, sw, oWCNT ← 0; oEN ← 0. Overrides a coincident iEN; that beat is discarded. odata holds its value.
- iEN=0: no state change; oEN ← 0.
- Unsigned compare only. A threshold of 0 always yields 1. A threshold above NSEG·WL always yields 0.

## Timing
- Reset (async assert, iRST=1): odata=0, oEN=0, oWCNT=0, seg=0, acc=0, bp=0, sw=0. The first beat is accepted on the first rising edge after iRST deasserts.
- One beat per cycle, back-to-back beats supported indefinitely, no bubbles required.
- Latency: oEN and odata are registered and valid in the cycle after the rising edge that captured the completing final beat (1-cycle latency).
- oEN is a single-cycle pulse. It is never asserted on two consecutive cycles unless both beats complete words (e.g. NSEG=1 with iLAST every beat).
- odata holds until the next emission; consumers sample only when oEN=1.
- Reset mid-neuron or mid-word: the partial accumulation and partial word are lost and no word is emitted.

## Test plan
- Reset: hold iRST over random iEN/idata, then release → odata=0, oEN=0, oWCNT=0. The first post-reset neuron lands in bit 0.
- Full word: NSEG=4, 112 neurons, each sending idata=30,30,30,30 (sum 120), iTHRESH=120 for even neurons and 121 for odd → one oEN pulse; odata bits alternate 1,0 starting at bit 0 (0x5555…5 pattern); oWCNT=1.
- Partial flush: 5 neurons with sums ≥ threshold, iLAST on the 5th final beat → odata=0x1F, upper bits 0. The next neuron goes to bit 0 of a fresh word.
- Boundaries: sum 448 (4×112) vs iTHRESH=448 → 1; vs 449 → 0; iTHRESH=0 with idata=0 → 1. Misplaced iLAST on beat 2 of 4 is ignored (no oEN).
- iCLR mid-neuron: two beats, then iCLR together with iEN → no oEN, oWCNT=0; the next 4 beats form neuron 0 using fresh accumulation only.
- Wrap and throughput: 256 consecutive full words, NSEG=1, iEN continuously high → 256 oEN pulses spaced WL cycles apart; oWCNT returns to 0.
